preg_release_queue: RTL and testbench

- Producer side of the physical-register free list: collects old physical destinations (pd_old) retired by ROB commit and returns them to the free list.
- Accepts up to two commits per cycle from the ROB and buffers them in order in a circular queue.
- Drains one register per cycle into the free list's write port (write_en/data_in).
- Stalls the drain while the free list is full or being restored after a mispredict, so no freed register is lost.

---
 rtl/preg_release_queue.sv | 87 ++++++++
 tb/tb_preg_release_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/preg_release_queue.sv
// preg_release_queue: buffers old physical destinations retired by ROB commit
// (up to two per cycle) and returns them, one per cycle and in commit order,
// to the physical-register free list. The drain holds while the free list is
// full or restoring a snapshot, so no freed register is ever dropped.
module preg_release_queue #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     commit0_valid,
  input  logic                     commit0_has_rd,
  input  logic [PREG_W-1:0]        commit0_pd_old,
  input  logic                     commit1_valid,
  input  logic                     commit1_has_rd,
  input  logic [PREG_W-1:0]        commit1_pd_old,
  output logic                     commit_ready,
  input  logic                     fl_full,
  input  logic                     mispredict,
  output logic                     fl_write_en,
  output logic [PREG_W-1:0]        fl_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PREG_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  slot1_idx;
  logic              q0;
  logic              q1;
  logic              pop;
  logic [1:0]        n_in;

  // Qualify commits (p0 is never freed), decide acceptance and drain, and
  // present the head entry to the free list.
  always_comb begin
    q0           = commit0_valid && commit0_has_rd && (commit0_pd_old != '0);
    q1           = commit1_valid && commit1_has_rd && (commit1_pd_old != '0);
    commit_ready = (count <= CNT_W'(DEPTH - 2));
    n_in         = 2'd0;
    if (commit_ready) begin
      n_in = {1'b0, q0} + {1'b0, q1};
    end
    slot1_idx    = q0 ? (tail + PTR_W'(1)) : tail;
    pop          = (count != '0) && !fl_full && !mispredict;
    fl_write_en  = pop;
    fl_data      = (count != '0) ? entries[head] : '0;
  end

  // Write accepted commits into the circular buffer; slot 1 lands after slot 0
  // when both qualify, otherwise at the tail itself.
  always_ff @(posedge clk) begin
    if (commit_ready) begin
      if (q0) begin
        entries[tail] <= commit0_pd_old;
      end
      if (q1) begin
        entries[slot1_idx] <= commit1_pd_old;
      end
    end
  end

  // Advance pointers and occupancy, and latch the sticky overflow flag when a
  // qualifying commit shows up while the queue cannot take two entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (pop) begin
        head <= head + PTR_W'(1);
      end
      tail  <= tail + PTR_W'(n_in);
      count <= count + CNT_W'(n_in) - CNT_W'(pop);
      if (!commit_ready && (q0 || q1)) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_preg_release_queue.sv
// tb_preg_release_queue: scoreboard bench for preg_release_queue. The stimulus
// side keeps an occupancy-level reference model and pushes every accepted
// register into an expected queue; a monitor pops and compares each drain.
module tb_preg_release_queue;

  localparam int DEPTH  = 8;
  localparam int PREG_W = 7;

  logic              clk;
  logic              reset;
  logic              commit0_valid;
  logic              commit0_has_rd;
  logic [PREG_W-1:0] commit0_pd_old;
  logic              commit1_valid;
  logic              commit1_has_rd;
  logic [PREG_W-1:0] commit1_pd_old;
  logic              commit_ready;
  logic              fl_full;
  logic              mispredict;
  logic              fl_write_en;
  logic [PREG_W-1:0] fl_data;
  logic [$clog2(DEPTH):0] count;
  logic              overflow_err;

  int n_compared  = 0;
  int n_mismatch  = 0;
  int exp_q[$];
  int occ = 0;
  int ovf = 0;

  preg_release_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .commit0_valid  (commit0_valid),
    .commit0_has_rd (commit0_has_rd),
    .commit0_pd_old (commit0_pd_old),
    .commit1_valid  (commit1_valid),
    .commit1_has_rd (commit1_has_rd),
    .commit1_pd_old (commit1_pd_old),
    .commit_ready   (commit_ready),
    .fl_full        (fl_full),
    .mispredict     (mispredict),
    .fl_write_en    (fl_write_en),
    .fl_data        (fl_data),
    .count          (count),
    .overflow_err   (overflow_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, check the state-level outputs against the
  // model, then advance the model as of the coming rising edge.
  task automatic apply_stimulus(input bit v0, input bit h0, input int p0,
                                input bit v1, input bit h1, input int p1,
                                input bit full, input bit misp);
    bit exp_pop;
    bit acc;
    bit qa;
    bit qb;
    @(negedge clk);
    commit0_valid  = v0;
    commit0_has_rd = h0;
    commit0_pd_old = PREG_W'(p0);
    commit1_valid  = v1;
    commit1_has_rd = h1;
    commit1_pd_old = PREG_W'(p1);
    fl_full        = full;
    mispredict     = misp;
    #1;
    exp_pop = (occ != 0) && !full && !misp;
    acc     = (occ <= DEPTH - 2);
    check_output("count", int'(count), occ);
    check_output("commit_ready", int'(commit_ready), int'(acc));
    check_output("overflow_err", int'(overflow_err), ovf);
    check_output("fl_write_en", int'(fl_write_en), int'(exp_pop));
    qa = v0 && h0 && (p0 != 0);
    qb = v1 && h1 && (p1 != 0);
    if (acc) begin
      if (qa) begin exp_q.push_back(p0); occ++; end
      if (qb) begin exp_q.push_back(p1); occ++; end
    end else if (qa || qb) begin
      ovf = 1;
    end
    if (exp_pop) occ--;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every drained register must be the oldest outstanding one.
  always @(negedge clk) begin
    #2;
    if (fl_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_output("drain_unexpected", 1, 0);
      end else begin
        check_output("drain_data", int'(fl_data), exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0;
    commit0_valid = 0; commit0_has_rd = 0; commit0_pd_old = '0;
    commit1_valid = 0; commit1_has_rd = 0; commit1_pd_old = '0;
    fl_full = 0; mispredict = 0;

    // Reset values
    #12;
    check_output("rst_count", int'(count), 0);
    check_output("rst_commit_ready", int'(commit_ready), 1);
    check_output("rst_fl_write_en", int'(fl_write_en), 0);
    check_output("rst_fl_data", int'(fl_data), 0);
    check_output("rst_overflow_err", int'(overflow_err), 0);
    #6 reset = 1'b1;

    // Single commit, then dual commit
    apply_stimulus(1, 1, 45, 0, 0, 0, 0, 0);
    idle(2);
    apply_stimulus(1, 1, 50, 1, 1, 51, 0, 0);
    idle(3);

    // Non-qualifying commits: p0 and no destination register
    apply_stimulus(1, 1, 0, 1, 0, 60, 0, 0);
    apply_stimulus(0, 1, 33, 1, 1, 0, 0, 0);
    idle(2);

    // Fill while the free list is full, overflow once, then drain across wrap
    for (int i = 0; i < 4; i++) apply_stimulus(1, 1, 32 + 2 * i, 1, 1, 33 + 2 * i, 1, 0);
    apply_stimulus(0, 0, 0, 1, 1, 99, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 1, 0);
    idle(10);

    // Mispredict holds the drain for one cycle without touching contents
    apply_stimulus(1, 1, 70, 1, 1, 71, 1, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    idle(4);

    // Asynchronous reset between edges with three entries queued
    apply_stimulus(1, 1, 80, 1, 1, 81, 1, 0);
    apply_stimulus(0, 0, 0, 1, 1, 82, 1, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_output("async_rst_fl_write_en", int'(fl_write_en), 0);
    check_output("async_rst_count", int'(count), 0);
    check_output("async_rst_commit_ready", int'(commit_ready), 1);
    check_output("async_rst_overflow_err", int'(overflow_err), 0);
    exp_q.delete();
    occ = 0;
    ovf = 0;
    idle(2);
    @(posedge clk);
    #3 reset = 1'b1;
    idle(4);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int pa;
      int pb;
      pa = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      pb = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      apply_stimulus($urandom_range(0, 1), $urandom_range(0, 3) != 0, pa,
                     $urandom_range(0, 1), $urandom_range(0, 3) != 0, pb,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end
    idle(DEPTH + 4);
    check_output("final_outstanding", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
